axi_rd_slave: RTL
=================

AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 64, read data width in bits (8..64, power of two).
REQ-002 SHALL have parameter ADDR_LIMIT, default 64'h0000_0001_0000_0000, first out-of-range byte address (used only with AXI_RD_SLAVE_RESP_EN).
REQ-003 SHALL use one clock and an asynchronous, active-low reset. Ports are clk and reset_n.
REQ-004 clk  input  1  sole clock; all state rising-edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 axi_aid  input  8  read transaction ID.
REQ-007 axi_addr  input  64  start byte address.
REQ-008 axi_alen  input  3  beats minus one (1..8 beats).
REQ-009 axi_asize  input  3  log2 bytes per beat.
REQ-010 axi_axvalid  input  1  address request valid.
REQ-011 axi_axready  output  1  address request accepted.
REQ-012 mem_rd  output  1  memory read strobe.
REQ-013 mem_addr  output  64  memory byte address.
REQ-014 mem_rddata  input  DATA_W  memory data, valid exactly 1 cycle after mem_rd.
REQ-015 axi_rid  output  8  returned ID.
REQ-016 axi_rdata  output  DATA_W  read data.
REQ-017 axi_rlast  output  1  final beat of burst.
REQ-018 axi_rvalid  output  1  read beat valid.
REQ-019 axi_rready  input  1  master accepts beat.

Function
REQ-020 States SHALL be IDLE, BURST, DRAIN. axi_axready SHALL be 1 only in IDLE.
REQ-021 On axi_axvalid&axi_axready the block SHALL capture aid/addr/alen/asize and enter BURST next cycle.
REQ-022 asize above log2(DATA_W/8) SHALL be clamped to log2(DATA_W/8).
REQ-023 In BURST, mem_rd SHALL assert when (reads in flight + buffered beats) < 2. mem_addr SHALL be start address + beat_index*(1<<asize), 64-bit wrap, INCR only.
REQ-024 The beat counter SHALL count issued reads. When the alen+1'th read issues, the state SHALL move to DRAIN.
REQ-025 Returned data SHALL enter a 2-entry FIFO. Its head drives axi_rdata, axi_rid, axi_rlast and axi_rvalid.
REQ-026 axi_rvalid, once asserted, SHALL hold with the same rdata, rid and rlast until axi_rready.
REQ-027 axi_rlast SHALL be 1 only on the beat carrying index alen.
REQ-028 In DRAIN, the state SHALL return to IDLE in the cycle after the rlast beat handshakes. No new request is accepted before that.
REQ-029 Latency: request handshake at cycle N gives mem_rd at N+1 and axi_rvalid at N+2. With axi_rready held 1, throughput SHALL be one beat per cycle.
REQ-030 When axi_rready=0 with the FIFO full, mem_rd SHALL stay 0. No beat is dropped or duplicated.

Reset
REQ-031 reset_n low SHALL immediately force: state IDLE, axi_axready 1, mem_rd 0, mem_addr 0, axi_rvalid 0, axi_rlast 0, axi_rid 0, axi_rdata 0, FIFO empty, counters 0.
REQ-032 Reset during a burst SHALL abandon it. No beat is emitted after reset release until a new request handshakes.

Configuration
REQ-033 With macro AXI_RD_SLAVE_RESP_EN defined:
- the block SHALL add output axi_rresp[1:0];
- a beat whose address is >= ADDR_LIMIT SHALL return SLVERR (2'b10) with rdata 0 and no mem_rd;
- all other beats SHALL return OKAY (2'b00);
- burst length and rlast are unchanged.
REQ-034 Without AXI_RD_SLAVE_RESP_EN, axi_rresp and the limit check SHALL be absent. ADDR_LIMIT is ignored.

Structure
REQ-035 A shared package axi_pkg SHALL hold:
- the state typedef (IDLE/BURST/DRAIN);
- the RESP_OKAY/RESP_SLVERR constants;
- the AID_W=8, LEN_W=3, SIZE_W=3 widths.
REQ-036 The 2-entry output FIFO SHALL be the sub-module axi_rd_skid (payload rid, rdata, rlast, optional rresp).

Verification
REQ-037 Single beat: aid=8'h5A, addr=64'h100, alen=0, asize=3, rready=1 -> mem_rd at N+1 with mem_addr=64'h100; rvalid at N+2; rid=8'h5A; rlast=1; axready=1 again after the handshake.
REQ-038 8-beat burst: addr=64'h1000, alen=7, asize=2, rready=1 -> mem_addr 64'h1000..64'h101C, step 4; 8 consecutive beats; rlast only on beat 8.
REQ-039 Backpressure: alen=3, rready toggled 1,0,0,1,... -> exactly 4 beats in order; data stable while stalled; at most 2 mem_rd ahead of acceptance.
REQ-040 Wrap: addr=64'hFFFF_FFFF_FFFF_FFF8, alen=1, asize=3 -> mem_addr FFFF_FFFF_FFFF_FFF8, then 64'h0.
REQ-041 Reset mid-burst: reset_n low during beat 3 of an alen=7 burst -> all outputs at reset values immediately; no rvalid after release until a new request.
REQ-042 With AXI_RD_SLAVE_RESP_EN and ADDR_LIMIT=64'h2000: addr=64'h1FF8, alen=1, asize=3 -> beat 1 OKAY with memory data; beat 2 SLVERR, rdata 0, no mem_rd, rlast=1.

Source files
------------

// File: rtl/axi_pkg.sv
// +--------------------------------------------------------------------------+
// | axi_pkg : shared types and constants for the AXI read slave (rev 1.0)    |
// +--------------------------------------------------------------------------+
`default_nettype none

package axi_pkg;

  localparam int unsigned AID_W  = 8;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] size,
                                                   input logic [SIZE_W-1:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rd_skid.sv
// +--------------------------------------------------------------------------+
// | axi_rd_skid : 2-entry fall-through beat FIFO; rresp with                 |
// | AXI_RD_SLAVE_RESP_EN (rev 1.0)                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_rd_skid
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [AID_W-1:0]  push_rid_i,
  input  logic [DATA_W-1:0] push_rdata_i,
  input  logic              push_rlast_i,
`ifdef AXI_RD_SLAVE_RESP_EN
  input  logic [RESP_W-1:0] push_rresp_i,
  output logic [RESP_W-1:0] rresp_o,
`endif
  input  logic              pop_i,
  output logic              valid_o,
  output logic [1:0]        count_o,
  output logic [AID_W-1:0]  rid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rlast_o
);

  logic [AID_W-1:0]  rid_q   [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic [1:0]        rlast_q;
`ifdef AXI_RD_SLAVE_RESP_EN
  logic [RESP_W-1:0] rresp_q [2];
`endif
  logic              rptr_q;
  logic              wptr_q;
  logic [1:0]        count_q;

  logic w_empty;
  logic w_bypass;
  logic w_store;
  logic w_pop_stored;

  // An empty FIFO presents the arriving beat directly; it is stored only if not taken.
  assign w_empty      = (count_q == 2'd0);
  assign w_bypass     = w_empty & push_i;
  assign w_store      = push_i & ~(w_bypass & pop_i);
  assign w_pop_stored = pop_i & ~w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        rid_q[i]   <= '0;
        rdata_q[i] <= '0;
`ifdef AXI_RD_SLAVE_RESP_EN
        rresp_q[i] <= RESP_OKAY;
`endif
      end
      rlast_q <= '0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (w_store) begin
        rid_q[wptr_q]   <= push_rid_i;
        rdata_q[wptr_q] <= push_rdata_i;
        rlast_q[wptr_q] <= push_rlast_i;
`ifdef AXI_RD_SLAVE_RESP_EN
        rresp_q[wptr_q] <= push_rresp_i;
`endif
        wptr_q <= ~wptr_q;
      end
      if (w_pop_stored) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_q + {1'b0, w_store} - {1'b0, w_pop_stored};
    end
  end

  assign valid_o = ~w_empty | push_i;
  assign count_o = count_q;
  assign rid_o   = w_bypass ? push_rid_i   : rid_q[rptr_q];
  assign rdata_o = w_bypass ? push_rdata_i : rdata_q[rptr_q];
  assign rlast_o = valid_o & (w_bypass ? push_rlast_i : rlast_q[rptr_q]);
`ifdef AXI_RD_SLAVE_RESP_EN
  assign rresp_o = w_bypass ? push_rresp_i : rresp_q[rptr_q];
`endif

endmodule

`default_nettype wire

// File: rtl/axi_rd_slave.sv
// +--------------------------------------------------------------------------+
// | axi_rd_slave : INCR burst read slave over a 1-cycle memory; the          |
// | AXI_RD_SLAVE_RESP_EN macro adds axi_rresp and the ADDR_LIMIT check (1.0) |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_rd_slave
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter logic [63:0] ADDR_LIMIT = 64'h0000_0001_0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AID_W-1:0]  axi_aid,
  input  logic [63:0]       axi_addr,
  input  logic [LEN_W-1:0]  axi_alen,
  input  logic [SIZE_W-1:0] axi_asize,
  input  logic              axi_axvalid,
  output logic              axi_axready,
  output logic              mem_rd,
  output logic [63:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rddata,
  output logic [AID_W-1:0]  axi_rid,
  output logic [DATA_W-1:0] axi_rdata,
`ifdef AXI_RD_SLAVE_RESP_EN
  output logic [RESP_W-1:0] axi_rresp,
`endif
  output logic              axi_rlast,
  output logic              axi_rvalid,
  input  logic              axi_rready
);

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'($clog2(DATA_W / 8));

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic [AID_W-1:0]  aid_q;
  logic [63:0]       addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [SIZE_W-1:0] size_q;
  logic              infl_q;
  logic              infl_last_q;
  logic              infl_err_q;

  logic              w_accept;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_room;
  logic              w_err;
  logic              w_pop;
  logic [63:0]       w_beat_addr;
  logic [1:0]        w_fifo_cnt;
  logic [DATA_W-1:0] w_push_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (axi_axvalid) state_d = BURST;
      BURST:   if (w_last_issue) state_d = DRAIN;
      DRAIN:   if (w_pop && axi_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_axready = 1'b0;
    w_issue     = 1'b0;
    unique case (state_q)
      IDLE:    axi_axready = 1'b1;
      BURST:   w_issue     = w_room;
      default: ;
    endcase
  end

  // A read is issued only while the read in flight plus stored beats leave a FIFO slot.
  assign w_room       = ({1'b0, infl_q} + w_fifo_cnt) < 2'd2;
  assign w_accept     = axi_axready & axi_axvalid;
  assign w_last_issue = w_issue & (beat_q == len_q);
  assign w_pop        = axi_rvalid & axi_rready;
  assign w_beat_addr  = addr_q + ({61'b0, beat_q} << size_q);

`ifdef AXI_RD_SLAVE_RESP_EN
  assign w_err = (w_beat_addr >= ADDR_LIMIT);
`else
  logic unused_addr_limit;
  assign unused_addr_limit = ^ADDR_LIMIT;
  assign w_err = 1'b0;
`endif

  assign mem_rd      = w_issue & ~w_err;
  assign mem_addr    = w_beat_addr;
  assign w_push_data = infl_err_q ? '0 : mem_rddata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aid_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      beat_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_err_q  <= 1'b0;
    end else begin
      if (w_accept) begin
        aid_q  <= axi_aid;
        addr_q <= axi_addr;
        len_q  <= axi_alen;
        size_q <= clamp_size(axi_asize, MAX_SIZE);
        beat_q <= '0;
      end else if (w_issue) begin
        beat_q <= beat_q + LEN_W'(1);
      end
      infl_q      <= w_issue;
      infl_last_q <= w_last_issue;
      infl_err_q  <= w_issue & w_err;
    end
  end

  axi_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (infl_q),
    .push_rid_i   (aid_q),
    .push_rdata_i (w_push_data),
    .push_rlast_i (infl_last_q),
`ifdef AXI_RD_SLAVE_RESP_EN
    .push_rresp_i (infl_err_q ? RESP_SLVERR : RESP_OKAY),
    .rresp_o      (axi_rresp),
`endif
    .pop_i        (w_pop),
    .valid_o      (axi_rvalid),
    .count_o      (w_fifo_cnt),
    .rid_o        (axi_rid),
    .rdata_o      (axi_rdata),
    .rlast_o      (axi_rlast)
  );

endmodule

`default_nettype wire
